// File: rtl/link_merge_tx.sv
// Serial link transmitter: merges radio and wire byte streams into tagged frames on one line.
// Optional parity bit enabled by defining LINK_TX_PARITY_EN.
`timescale 1ns/1ps
module link_merge_tx #(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned IDLE_BITS    = 2
) (
    input  logic       Clock100Mhz,
    input  logic       ResetN,
    input  logic [7:0] RadioData,
    input  logic       RadioValid,
    output logic       RadioReady,
    input  logic [7:0] WireData,
    input  logic       WireValid,
    output logic       WireReady,
    output logic       LinkTx,
    output logic       Busy,
    output logic       FrameDone
);

    localparam int unsigned TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_MAX = (IDLE_BITS > 8) ? IDLE_BITS : 8;
    localparam int unsigned IDX_W   = $clog2(IDX_MAX);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]   DATA_LAST  = IDX_W'(7);
    localparam logic [IDX_W-1:0]   GAP_LAST   = IDX_W'(IDLE_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StChan,
        StData,
        StParity,
        StStop,
        StGap
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [TIMER_W-1:0]  r_timer;
    logic [TIMER_W-1:0]  w_timer_next;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [IDX_W-1:0]    w_idx_next;
    logic [7:0]          r_data;
    logic                r_tag;
    logic                r_ptr;

    logic w_idle;
    logic w_wrap;
    logic w_radio_ready;
    logic w_wire_ready;
    logic w_accept_radio;
    logic w_accept_wire;
    logic w_accept;
    logic w_tx;

    assign w_idle = (r_state == StIdle);
    assign w_wrap = (r_timer == TIMER_LAST);

    // Readies are held low while reset is asserted, even though the state already reads idle.
    assign w_radio_ready  = ResetN && w_idle && (!WireValid || !r_ptr);
    assign w_wire_ready   = ResetN && w_idle && (!RadioValid || r_ptr);
    assign w_accept_radio = RadioValid && w_radio_ready;
    assign w_accept_wire  = WireValid && w_wire_ready;
    assign w_accept       = w_accept_radio || w_accept_wire;

    always_ff @(posedge Clock100Mhz or negedge ResetN) begin
        if (!ResetN) begin
            r_state   <= StIdle;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_tag     <= 1'b0;
            r_ptr     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_idx <= w_idx_next;
            if (w_accept) begin
                r_data <= w_accept_radio ? RadioData : WireData;
                r_tag  <= w_accept_wire;
                r_ptr  <= w_accept_radio;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_bit_idx;
        w_timer_next = w_wrap ? '0 : r_timer + 1'b1;
        unique case (r_state)
            StIdle: begin
                w_timer_next = '0;
                w_idx_next   = '0;
                if (w_accept) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (w_wrap) begin
                    w_state_next = StChan;
                end
            end
            StChan: begin
                if (w_wrap) begin
                    w_state_next = StData;
                    w_idx_next   = '0;
                end
            end
            StData: begin
                if (w_wrap) begin
                    if (r_bit_idx == DATA_LAST) begin
`ifdef LINK_TX_PARITY_EN
                        w_state_next = StParity;
`else
                        w_state_next = StStop;
`endif
                        w_idx_next = '0;
                    end else begin
                        w_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            StParity: begin
                if (w_wrap) begin
                    w_state_next = StStop;
                end
            end
            StStop: begin
                if (w_wrap) begin
                    w_state_next = StGap;
                    w_idx_next   = '0;
                end
            end
            StGap: begin
                // Bit index doubles as the gap bit-period counter.
                if (w_wrap) begin
                    if (r_bit_idx == GAP_LAST) begin
                        w_state_next = StIdle;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
                w_idx_next   = '0;
                w_timer_next = '0;
            end
        endcase
    end

    always_comb begin
        w_tx = 1'b0;
        unique case (r_state)
            StStart: w_tx = 1'b1;
            StChan:  w_tx = r_tag;
            StData:  w_tx = r_data[r_bit_idx[2:0]];
`ifdef LINK_TX_PARITY_EN
            StParity: w_tx = r_tag ^ (^r_data);
`endif
            default: w_tx = 1'b0;
        endcase
    end

    assign LinkTx     = w_tx;
    assign Busy       = !w_idle;
    assign FrameDone  = (r_state == StStop) && w_wrap;
    assign RadioReady = w_radio_ready;
    assign WireReady  = w_wire_ready;

endmodule
